// File: rtl/controle_movimento_elevador_if.sv
// Signal bundle between the floor-request memory (master) and the motion/door controller (slave).
// The segurar_porta wire only exists when SEGURAR_PORTA_EN is defined.
interface controle_movimento_elevador_if;
  logic [1:0] proximo_andar;
  logic       pedido_andar_atual;
  logic [1:0] andar_atual;
  logic       movimento_elevador;
  logic       indicador_porta_aberta;
  logic       motor_ligado;
`ifdef SEGURAR_PORTA_EN
  logic       segurar_porta;

  modport master (
    output proximo_andar, pedido_andar_atual, segurar_porta,
    input  andar_atual, movimento_elevador, indicador_porta_aberta, motor_ligado
  );

  modport slave (
    input  proximo_andar, pedido_andar_atual, segurar_porta,
    output andar_atual, movimento_elevador, indicador_porta_aberta, motor_ligado
  );
`else
  modport master (
    output proximo_andar, pedido_andar_atual,
    input  andar_atual, movimento_elevador, indicador_porta_aberta, motor_ligado
  );

  modport slave (
    input  proximo_andar, pedido_andar_atual,
    output andar_atual, movimento_elevador, indicador_porta_aberta, motor_ligado
  );
`endif
endinterface

// File: rtl/controle_movimento_elevador.sv
// Elevator motion/door controller fed by the floor-request memory; travel and door dwell are counter timed.
// Optional door-hold button enabled by defining SEGURAR_PORTA_EN.
module controle_movimento_elevador #(
  parameter int unsigned CICLOS_POR_ANDAR = 4,
  parameter int unsigned CICLOS_PORTA     = 5
) (
  input logic                          clock_in,
  input logic                          reset,
  controle_movimento_elevador_if.slave bus
);

  localparam logic [3:0] ULTIMO_CICLO_ANDAR = 4'(CICLOS_POR_ANDAR - 1);
  localparam logic [3:0] CARGA_PORTA        = 4'(CICLOS_PORTA);
  localparam logic [1:0] ANDAR_TOPO         = 2'd3;

  typedef enum logic [1:0] {
    PARADO,
    MOVENDO,
    CHEGADA,
    PORTA_ABERTA
  } estado_t;

  estado_t    state_q, state_d;
  logic [1:0] andar_q, andar_d;
  logic       dir_q, dir_d;
  logic       porta_q, porta_d;
  logic       motor_q, motor_d;
  logic [3:0] cnt_viagem_q, cnt_viagem_d;
  logic [3:0] cnt_porta_q, cnt_porta_d;
  logic       segurar;

`ifdef SEGURAR_PORTA_EN
  assign segurar = bus.segurar_porta;
`else
  assign segurar = 1'b0;
`endif

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state_q      <= PARADO;
      andar_q      <= 2'd0;
      dir_q        <= 1'b1;
      porta_q      <= 1'b0;
      motor_q      <= 1'b0;
      cnt_viagem_q <= 4'd0;
      cnt_porta_q  <= 4'd0;
    end else begin
      state_q      <= state_d;
      andar_q      <= andar_d;
      dir_q        <= dir_d;
      porta_q      <= porta_d;
      motor_q      <= motor_d;
      cnt_viagem_q <= cnt_viagem_d;
      cnt_porta_q  <= cnt_porta_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    andar_d      = andar_q;
    dir_d        = dir_q;
    cnt_viagem_d = cnt_viagem_q;
    cnt_porta_d  = cnt_porta_q;

    case (state_q)
      // CHEGADA shares PARADO's decision: a pending local request beats departure, and
      // a target equal to the current floor falls through to PARADO.
      PARADO, CHEGADA: begin
        cnt_viagem_d = 4'd0;
        if (bus.pedido_andar_atual) begin
          state_d     = PORTA_ABERTA;
          cnt_porta_d = CARGA_PORTA;
        end else if ((bus.proximo_andar > andar_q) && (andar_q != ANDAR_TOPO)) begin
          state_d = MOVENDO;
          dir_d   = 1'b1;
        end else if ((bus.proximo_andar < andar_q) && (andar_q != 2'd0)) begin
          state_d = MOVENDO;
          dir_d   = 1'b0;
        end else begin
          state_d = PARADO;
        end
      end

      MOVENDO: begin
        if (cnt_viagem_q >= ULTIMO_CICLO_ANDAR) begin
          cnt_viagem_d = 4'd0;
          state_d      = CHEGADA;
          if (dir_q && (andar_q != ANDAR_TOPO)) begin
            andar_d = andar_q + 2'd1;
          end else if (!dir_q && (andar_q != 2'd0)) begin
            andar_d = andar_q - 2'd1;
          end
        end else begin
          cnt_viagem_d = cnt_viagem_q + 4'd1;
        end
      end

      PORTA_ABERTA: begin
        if (segurar) begin
          cnt_porta_d = CARGA_PORTA;
        end else if (cnt_porta_q <= 4'd1) begin
          cnt_porta_d = 4'd0;
          state_d     = PARADO;
        end else begin
          cnt_porta_d = cnt_porta_q - 4'd1;
        end
      end

      default: state_d = PARADO;
    endcase

    motor_d = (state_d == MOVENDO);
    porta_d = (state_d == PORTA_ABERTA);
  end

  assign bus.andar_atual            = andar_q;
  assign bus.movimento_elevador     = dir_q;
  assign bus.indicador_porta_aberta = porta_q;
  assign bus.motor_ligado           = motor_q;

endmodule
